ctrl_decode_pipe: RTL and testbench

//  Registered, parametrised RV32/RV64 control decoder for the decode stage. Accepts

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/ctrl_decode_comb.sv | 199 +++++++++++++++++++
 rtl/ctrl_decode_pipe.sv | 117 +++++++++++
 tb/tb_ctrl_decode_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction formats,
// write-back selects and the ctrl_t control word handed to execute.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // One-hot format, MSB first in the order R, I, S, B, U, J
    localparam logic [5:0] FMT_R = 6'b100000;
    localparam logic [5:0] FMT_I = 6'b010000;
    localparam logic [5:0] FMT_S = 6'b001000;
    localparam logic [5:0] FMT_B = 6'b000100;
    localparam logic [5:0] FMT_U = 6'b000010;
    localparam logic [5:0] FMT_J = 6'b000001;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MEM = 3'd1;
    localparam logic [2:0] WB_PC4 = 3'd2;
    localparam logic [2:0] WB_IMM = 3'd3;
    localparam logic [2:0] WB_CSR = 3'd4;

    typedef struct packed {
        logic [5:0] fmt;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       alu_sub;
        logic       alu_uns;
        logic       alu_arith;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       dmem_zext;
        logic [1:0] dmem_size;
        logic [2:0] wb_sel;
        logic       reg_wr_en;
        logic       word;
        logic       muldiv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       halt;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational RV32/RV64 instruction-to-ctrl_t decoder.
// Build option: CTRL_DECODE_MULDIV_EN enables the M-extension encodings.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic [5:0] funct6_s;
    logic       shamt_hi_bad_s;
    ctrl_t      ctrl_s;
    logic       ill_s;

    assign opcode_s       = i_instr[6:0];
    assign funct3_s       = i_instr[14:12];
    assign funct7_s       = i_instr[31:25];
    assign funct6_s       = i_instr[31:26];
    // On RV32 bit 25 would be a sixth shamt bit, which does not exist
    assign shamt_hi_bad_s = RV64 ? 1'b0 : i_instr[25];

    // Opcode/funct decode into the control word, then squash side effects of halts
    always_comb begin
        ctrl_s     = '0;
        ill_s      = 1'b0;
        ctrl_s.rs1 = i_instr[19:15];
        ctrl_s.rs2 = i_instr[24:20];
        ctrl_s.rd  = i_instr[11:7];
        case (opcode_s)
            OPC_LUI: begin
                ctrl_s.fmt       = FMT_U;
                ctrl_s.wb_sel    = WB_IMM;
                ctrl_s.reg_wr_en = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_s.fmt       = FMT_U;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.wb_sel    = WB_ALU;
                ctrl_s.reg_wr_en = 1'b1;
            end
            OPC_JAL: begin
                ctrl_s.fmt       = FMT_J;
                ctrl_s.jump      = 1'b1;
                ctrl_s.wb_sel    = WB_PC4;
                ctrl_s.reg_wr_en = 1'b1;
            end
            OPC_JALR: begin
                ctrl_s.fmt       = FMT_I;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.jump      = 1'b1;
                ctrl_s.jalr      = 1'b1;
                ctrl_s.wb_sel    = WB_PC4;
                ctrl_s.reg_wr_en = 1'b1;
                ill_s            = (funct3_s != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl_s.fmt     = FMT_B;
                ctrl_s.branch  = 1'b1;
                ctrl_s.alu_sub = 1'b1;
                ctrl_s.alu_op  = funct3_s;
                ctrl_s.alu_uns = funct3_s[1];
                ill_s          = (funct3_s[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                ctrl_s.fmt       = FMT_I;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.dmem_rd   = 1'b1;
                ctrl_s.dmem_size = funct3_s[1:0];
                ctrl_s.dmem_zext = funct3_s[2];
                ctrl_s.wb_sel    = WB_MEM;
                ctrl_s.reg_wr_en = 1'b1;
                ill_s = (funct3_s == 3'b111) ||
                        (!RV64 && ((funct3_s == 3'b011) || (funct3_s == 3'b110)));
            end
            OPC_STORE: begin
                ctrl_s.fmt       = FMT_S;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.dmem_wr   = 1'b1;
                ctrl_s.dmem_size = funct3_s[1:0];
                ill_s = funct3_s[2] || (!RV64 && (funct3_s[1:0] == 2'b11));
            end
            OPC_OP_IMM: begin
                ctrl_s.fmt       = FMT_I;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = funct3_s;
                ctrl_s.wb_sel    = WB_ALU;
                ctrl_s.reg_wr_en = 1'b1;
                case (funct3_s)
                    3'b001: ill_s = (funct6_s != 6'b000000) || shamt_hi_bad_s;
                    3'b101: begin
                        ctrl_s.alu_arith = i_instr[30];
                        ill_s = ((funct6_s != 6'b000000) && (funct6_s != 6'b010000)) ||
                                shamt_hi_bad_s;
                    end
                    3'b011: ctrl_s.alu_uns = 1'b1;
                    default: ill_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                ctrl_s.fmt       = FMT_R;
                ctrl_s.alu_op    = funct3_s;
                ctrl_s.wb_sel    = WB_ALU;
                ctrl_s.reg_wr_en = 1'b1;
                case (funct7_s)
                    7'b0000000: ctrl_s.alu_uns = (funct3_s == 3'b011);
                    7'b0100000: begin
                        ctrl_s.alu_sub   = (funct3_s == 3'b000);
                        ctrl_s.alu_arith = (funct3_s == 3'b101);
                        ill_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                    end
                    7'b0000001: begin
`ifdef CTRL_DECODE_MULDIV_EN
                        ctrl_s.muldiv = 1'b1;
`else
                        ill_s = 1'b1;
`endif
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                if (!RV64) begin
                    ill_s = 1'b1;
                end else begin
                    ctrl_s.fmt       = FMT_I;
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.alu_op    = funct3_s;
                    ctrl_s.wb_sel    = WB_ALU;
                    ctrl_s.reg_wr_en = 1'b1;
                    ctrl_s.word      = 1'b1;
                    case (funct3_s)
                        3'b000: ill_s = 1'b0;
                        3'b001: ill_s = (funct7_s != 7'b0000000);
                        3'b101: begin
                            ctrl_s.alu_arith = i_instr[30];
                            ill_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
                        end
                        default: ill_s = 1'b1;
                    endcase
                end
            end
            OPC_OP_32: begin
                if (!RV64) begin
                    ill_s = 1'b1;
                end else begin
                    ctrl_s.fmt       = FMT_R;
                    ctrl_s.alu_op    = funct3_s;
                    ctrl_s.wb_sel    = WB_ALU;
                    ctrl_s.reg_wr_en = 1'b1;
                    ctrl_s.word      = 1'b1;
                    case (funct7_s)
                        7'b0000000: ill_s = !((funct3_s == 3'b000) || (funct3_s == 3'b001) ||
                                              (funct3_s == 3'b101));
                        7'b0100000: begin
                            ctrl_s.alu_sub   = (funct3_s == 3'b000);
                            ctrl_s.alu_arith = (funct3_s == 3'b101);
                            ill_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                        end
                        7'b0000001: begin
`ifdef CTRL_DECODE_MULDIV_EN
                            ctrl_s.muldiv = 1'b1;
                            ill_s = (funct3_s == 3'b001) || (funct3_s == 3'b010) ||
                                    (funct3_s == 3'b011);
`else
                            ill_s = 1'b1;
`endif
                        end
                        default: ill_s = 1'b1;
                    endcase
                end
            end
            OPC_MISC_MEM: ctrl_s.fmt = FMT_I;
            OPC_SYSTEM: begin
                ctrl_s.fmt    = FMT_I;
                ctrl_s.wb_sel = WB_CSR;
                ctrl_s.halt   = 1'b1;
            end
            default: ill_s = 1'b1;
        endcase
        // An illegal word stops the machine exactly like a halt
        ctrl_s.halt      = ctrl_s.halt | ill_s;
        ctrl_s.reg_wr_en = ctrl_s.reg_wr_en & ~ctrl_s.halt;
        ctrl_s.dmem_rd   = ctrl_s.dmem_rd & ~ctrl_s.halt;
        ctrl_s.dmem_wr   = ctrl_s.dmem_wr & ~ctrl_s.halt;
        ctrl_s.jump      = ctrl_s.jump & ~ctrl_s.halt;
    end

    assign o_ctrl    = ctrl_s;
    assign o_illegal = ill_s;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Decode stage: decodes accepted instructions into a 2-entry skid buffer feeding execute,
// with flush, halt blocking and a sticky halted flag. Build option: CTRL_DECODE_MULDIV_EN.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_illegal,
    output logic              o_halted
);

    ctrl_t           dec_ctrl_s;
    logic            dec_ill_s;
    logic            accept_s;
    logic            pop_s;
    logic            head_halt_s;
    logic            wr_idx_s;

    ctrl_t           ctrl_q [2];
    ctrl_t           ctrl_d [2];
    logic [XLEN-1:0] pc_q   [2];
    logic [XLEN-1:0] pc_d   [2];
    logic [1:0]      ill_q;
    logic [1:0]      ill_d;
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            halt_pend_q;
    logic            halt_pend_d;
    logic            halted_q;
    logic            halted_d;

    ctrl_decode_comb #(
        .XLEN (XLEN)
    ) u_dec (
        .i_instr   (i_instr),
        .o_ctrl    (dec_ctrl_s),
        .o_illegal (dec_ill_s)
    );

    assign o_ready     = i_rst & (count_q < 2'(DEPTH)) & ~halt_pend_q & ~halted_q & ~i_flush;
    assign o_valid     = (count_q != 2'd0);
    assign accept_s    = i_valid & o_ready;
    assign pop_s       = o_valid & i_ready;
    assign head_halt_s = ctrl_q[0].halt | ill_q[0];
    // Slot for a new entry: first free slot after any pop has shifted the tail forward
    assign wr_idx_s    = count_q[0] ^ pop_s;

    // Skid-buffer shift/write, occupancy and halt tracking
    always_comb begin
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        ill_d  = ill_q;
        if (pop_s) begin
            ctrl_d[0] = ctrl_q[1];
            pc_d[0]   = pc_q[1];
            ill_d[0]  = ill_q[1];
        end else begin
            ctrl_d[0] = ctrl_q[0];
            pc_d[0]   = pc_q[0];
            ill_d[0]  = ill_q[0];
        end
        if (accept_s) begin
            ctrl_d[wr_idx_s] = dec_ctrl_s;
            pc_d[wr_idx_s]   = i_pc;
            ill_d[wr_idx_s]  = dec_ill_s;
        end else begin
            ctrl_d[1] = ctrl_d[1];
        end
        if (i_flush) begin
            count_d     = 2'd0;
            halt_pend_d = 1'b0;
        end else begin
            count_d     = count_q + {1'b0, accept_s} - {1'b0, pop_s};
            halt_pend_d = halt_pend_q | (accept_s & (dec_ctrl_s.halt | dec_ill_s));
        end
        halted_d = halted_q | (pop_s & head_halt_s);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ctrl_q[0]   <= '0;
            ctrl_q[1]   <= '0;
            pc_q[0]     <= '0;
            pc_q[1]     <= '0;
            ill_q       <= 2'b00;
            count_q     <= 2'd0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            ill_q       <= ill_d;
            count_q     <= count_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
        end
    end

    assign o_ctrl    = ctrl_q[0];
    assign o_pc      = pc_q[0];
    assign o_illegal = ill_q[0];
    assign o_halted  = halted_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed self-checking bench for ctrl_decode_pipe: an XLEN=32 and an XLEN=64 instance
// share one clock; expected values are hand-decoded instruction fields.
module tb_ctrl_decode_pipe;
    import ctrl_pkg::*;

`ifdef CTRL_DECODE_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402082B3;
    localparam logic [31:0] I_ADDI = 32'h00508313;
    localparam logic [31:0] I_LW   = 32'h0040A383;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_ECAL = 32'h00000073;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_LD   = 32'h0000B183;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_ADDW = 32'h002081BB;
    localparam logic [31:0] I_MULW = 32'h022081BB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, valid, ready_o, flush, valid_o, ready_i, illegal_o, halted_o;
    logic [31:0]       instr, pc, pc_o;
    logic [CTRL_W-1:0] ctrl_o;
    ctrl_t             c;
    assign c = ctrl_o;

    logic              valid64, ready_o64, valid_o64, illegal_o64, halted_o64;
    logic [31:0]       instr64;
    logic [63:0]       pc64, pc_o64;
    logic [CTRL_W-1:0] ctrl_o64;
    ctrl_t             c64;
    assign c64 = ctrl_o64;

    int total = 0;
    int bad   = 0;

    ctrl_decode_pipe #(.XLEN(32)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .o_ready(ready_o), .i_instr(instr),
        .i_pc(pc), .i_flush(flush), .o_valid(valid_o), .i_ready(ready_i), .o_ctrl(ctrl_o),
        .o_pc(pc_o), .o_illegal(illegal_o), .o_halted(halted_o)
    );

    ctrl_decode_pipe #(.XLEN(64)) u_dut64 (
        .i_clk(clk), .i_rst(rst_n), .i_valid(valid64), .o_ready(ready_o64), .i_instr(instr64),
        .i_pc(pc64), .i_flush(1'b0), .o_valid(valid_o64), .i_ready(1'b1), .o_ctrl(ctrl_o64),
        .o_pc(pc_o64), .o_illegal(illegal_o64), .o_halted(halted_o64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ready_i = 1'b0; valid64 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ready_i = 1'b0; valid64 = 1'b0;
        instr = 32'h0; pc = 32'h0; instr64 = 32'h0; pc64 = 64'h0;
        tick(); tick();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready_o); end
        total++; if (halted_o !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted_o); end
        total++; if (ctrl_o !== '0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", ctrl_o); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_o); end
        total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b want=0", illegal_o); end
        rst_n = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", ready_o); end
    endtask

    task automatic test_add();
        ready_i = 1'b1; instr = I_ADD; pc = 32'h100; valid = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL add_pre_valid got=%b want=0", valid_o); end
        tick();
        valid = 1'b0;
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", valid_o); end
        total++; if (c.fmt !== FMT_R) begin bad++; $display("FAIL add_fmt got=%b want=%b", c.fmt, FMT_R); end
        total++; if (c.reg_wr_en !== 1'b1) begin bad++; $display("FAIL add_wr got=%b want=1", c.reg_wr_en); end
        total++; if (c.alu_sub !== 1'b0) begin bad++; $display("FAIL add_sub got=%b want=0", c.alu_sub); end
        total++; if (c.rd !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d want=3", c.rd); end
        total++; if ({c.rs1, c.rs2} !== {5'd1, 5'd2}) begin bad++; $display("FAIL add_rs got=%0d,%0d want=1,2", c.rs1, c.rs2); end
        total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL add_pc got=%h want=100", pc_o); end
        tick();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", valid_o); end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0; valid = 1'b1; instr = I_ADD; pc = 32'h100;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_rdy0 got=%b want=1", ready_o); end
        tick();
        instr = I_SUB; pc = 32'h104;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%b want=1", ready_o); end
        tick();
        instr = I_ADDI; pc = 32'h108;
        #1;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", ready_o); end
        tick();
        total++; if ({c.rd, pc_o} !== {5'd3, 32'h100}) begin bad++; $display("FAIL b2b_head0 got=%0d/%h want=3/100", c.rd, pc_o); end
        ready_i = 1'b1;
        tick();
        total++; if ({c.rd, pc_o} !== {5'd5, 32'h104}) begin bad++; $display("FAIL b2b_head1 got=%0d/%h want=5/104", c.rd, pc_o); end
        total++; if (c.alu_sub !== 1'b1) begin bad++; $display("FAIL b2b_sub got=%b want=1", c.alu_sub); end
        tick();
        valid = 1'b0;
        total++; if ({c.rd, pc_o} !== {5'd6, 32'h108}) begin bad++; $display("FAIL b2b_head2 got=%0d/%h want=6/108", c.rd, pc_o); end
        total++; if ({c.fmt, c.alu_src} !== {FMT_I, 1'b1}) begin bad++; $display("FAIL b2b_addi got=%b/%b want=%b/1", c.fmt, c.alu_src, FMT_I); end
        tick();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", valid_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid = 1'b1; instr = I_LW; pc = 32'h200;
        tick();
        instr = I_SW; pc = 32'h204;
        tick();
        valid = 1'b0;
        total++; if ({c.dmem_rd, c.dmem_size, c.dmem_zext} !== {1'b1, 2'b10, 1'b0}) begin bad++; $display("FAIL lw_mem got=%b%b%b want=1100", c.dmem_rd, c.dmem_size, c.dmem_zext); end
        total++; if ({c.wb_sel, c.reg_wr_en} !== {WB_MEM, 1'b1}) begin bad++; $display("FAIL lw_wb got=%0d/%b want=%0d/1", c.wb_sel, c.reg_wr_en, WB_MEM); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total++; if ({c.fmt, c.dmem_wr, c.reg_wr_en, pc_o} !== {FMT_S, 1'b1, 1'b0, 32'h204}) begin bad++; $display("FAIL sw_dec got=%b/%b/%b/%h want=%b/1/0/204", c.fmt, c.dmem_wr, c.reg_wr_en, pc_o, FMT_S); end
        instr = I_BEQ; pc = 32'h208; valid = 1'b1;
        tick();
        valid = 1'b0; ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total++; if ({c.fmt, c.branch, c.alu_sub, c.reg_wr_en} !== {FMT_B, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL beq_dec got=%b/%b/%b/%b want=%b/1/1/0", c.fmt, c.branch, c.alu_sub, c.reg_wr_en, FMT_B); end
        instr = I_LW; pc = 32'h20C; valid = 1'b1;
        tick();
        flush = 1'b1; instr = I_ADD; pc = 32'h210;
        #1;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", ready_o); end
        tick();
        flush = 1'b0; valid = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", valid_o); end
        tick();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flush_reopen got=%b want=1", ready_o); end
    endtask

    task automatic test_ecall();
        ready_i = 1'b0; valid = 1'b1; instr = I_ECAL; pc = 32'h300;
        tick();
        instr = I_ADD; pc = 32'h304;
        #1;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ecall_ready got=%b want=0", ready_o); end
        total++; if ({c.halt, c.reg_wr_en, illegal_o} !== 3'b100) begin bad++; $display("FAIL ecall_dec got=%b%b%b want=100", c.halt, c.reg_wr_en, illegal_o); end
        ready_i = 1'b1;
        tick();
        total++; if ({halted_o, valid_o} !== 2'b10) begin bad++; $display("FAIL ecall_halted got=%b%b want=10", halted_o, valid_o); end
        valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        total++; if ({halted_o, ready_o} !== 2'b10) begin bad++; $display("FAIL ecall_sticky got=%b%b want=10", halted_o, ready_o); end
        do_reset();
    endtask

    task automatic test_illegal();
        ready_i = 1'b0; valid = 1'b1; instr = I_BAD; pc = 32'h400;
        tick();
        valid = 1'b0;
        total++; if ({illegal_o, c.reg_wr_en, c.dmem_wr} !== 3'b100) begin bad++; $display("FAIL bad_dec got=%b%b%b want=100", illegal_o, c.reg_wr_en, c.dmem_wr); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bad_ready got=%b want=0", ready_o); end
        ready_i = 1'b1;
        tick();
        total++; if (halted_o !== 1'b1) begin bad++; $display("FAIL bad_halted got=%b want=1", halted_o); end
        do_reset();
        ready_i = 1'b1; valid = 1'b1; instr = I_LD; pc = 32'h404;
        tick();
        valid = 1'b0;
        total++; if ({illegal_o, c.dmem_rd} !== 2'b10) begin bad++; $display("FAIL ld32_illegal got=%b%b want=10", illegal_o, c.dmem_rd); end
        do_reset();
    endtask

    task automatic test_muldiv_word();
        ready_i = 1'b1; valid = 1'b1; instr = I_MUL; pc = 32'h500;
        tick();
        valid = 1'b0;
        total++; if ({c.muldiv, illegal_o, c.reg_wr_en} !== {MD, ~MD, MD}) begin bad++; $display("FAIL mul32 got=%b%b%b want=%b%b%b", c.muldiv, illegal_o, c.reg_wr_en, MD, ~MD, MD); end
        do_reset();
        ready_i = 1'b1; valid = 1'b1; instr = I_ADDW; pc = 32'h504;
        tick();
        valid = 1'b0;
        total++; if ({illegal_o, c.word} !== 2'b10) begin bad++; $display("FAIL addw32 got=%b%b want=10", illegal_o, c.word); end
        do_reset();
        valid64 = 1'b1; instr64 = I_ADDW; pc64 = 64'h0000_0001_0000_0000;
        tick();
        valid64 = 1'b0;
        total++; if ({illegal_o64, c64.word, c64.reg_wr_en, c64.muldiv} !== 4'b0110) begin bad++; $display("FAIL addw64 got=%b%b%b%b want=0110", illegal_o64, c64.word, c64.reg_wr_en, c64.muldiv); end
        total++; if ({c64.fmt, pc_o64} !== {FMT_R, 64'h0000_0001_0000_0000}) begin bad++; $display("FAIL addw64_fmt_pc got=%b/%h want=%b/100000000", c64.fmt, pc_o64, FMT_R); end
        tick();
        valid64 = 1'b1; instr64 = I_LD; pc64 = 64'h8;
        tick();
        valid64 = 1'b0;
        total++; if ({illegal_o64, c64.dmem_rd, c64.dmem_size} !== 4'b0111) begin bad++; $display("FAIL ld64 got=%b%b%b want=0111", illegal_o64, c64.dmem_rd, c64.dmem_size); end
        tick();
        valid64 = 1'b1; instr64 = I_MULW; pc64 = 64'h10;
        tick();
        valid64 = 1'b0;
        total++; if ({c64.muldiv, illegal_o64} !== {MD, ~MD}) begin bad++; $display("FAIL mulw64 got=%b%b want=%b%b", c64.muldiv, illegal_o64, MD, ~MD); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_flush();
        test_ecall();
        test_illegal();
        test_muldiv_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
